// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit (master) and its neighbours (slave):
// the instruction RAM port, the instruction hand-off to execute, and the
// redirect/halt controls coming back from execute.
// Optional macro: FETCH_STALL_CNT_EN adds the 16-bit stall_cnt signal.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cs;
  logic                  mem_oe;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] ir_data;
  logic [ADDR_WIDTH-1:0] ir_pc;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic                  halted;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  modport master (
    output mem_addr, mem_cs, mem_oe, mem_we,
    input  mem_rdata,
    output ir_data, ir_pc, ir_valid,
    input  ir_ready, redirect_valid, redirect_pc, halt,
    output halted
`ifdef FETCH_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    input  mem_addr, mem_cs, mem_oe, mem_we,
    output mem_rdata,
    input  ir_data, ir_pc, ir_valid,
    output ir_ready, redirect_valid, redirect_pc, halt,
    input  halted
`ifdef FETCH_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: ADDR -> WAIT -> HOLD loop against a RAM with one
// cycle read latency, with redirect (jump/skip) and halt support.
// Optional macro: FETCH_STALL_CNT_EN adds a saturating HOLD-stall counter.
module instr_fetch_unit #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = 'h100,
  parameter int unsigned PC_STEP    = 2
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_ADDR,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] ir_data_q,  ir_data_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q,    ir_pc_d;
  logic                  ir_valid_q, ir_valid_d;

  // State and instruction registers; reset is synchronous.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking assigns here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ADDR;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Next-state logic: redirect overrides halt, halt overrides the handshake.
  // NOTE: every signal gets a hold default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (bus.redirect_valid) begin
      // Any read in flight is dropped simply by not capturing it.
      pc_d       = bus.redirect_pc;
      ir_valid_d = 1'b0;
      state_d    = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR: state_d = bus.halt ? S_HALT : S_WAIT;
        S_WAIT: begin
          ir_data_d  = bus.mem_rdata;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_WIDTH'(PC_STEP);  // wraps past max address
          state_d    = S_HOLD;
        end
        S_HOLD: begin
          if (bus.ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = bus.halt ? S_HALT : S_ADDR;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_ADDR;
      endcase
    end
  end

  // RAM strobes: a read goes out only in ADDR, and never while reset,
  // redirect or halt would throw it away.
  logic rd_en;
  assign rd_en = (state_q == S_ADDR) && !rst && !bus.redirect_valid && !bus.halt;

  assign bus.mem_addr = pc_q;
  assign bus.mem_cs   = rd_en;
  assign bus.mem_oe   = rd_en;
  assign bus.mem_we   = 1'b0;
  assign bus.ir_data  = ir_data_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = (state_q == S_HALT);

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count HOLD cycles where execute did not take the instruction; saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_HOLD && !bus.ir_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction and memory data width.
REQ-003 SHALL have parameter RESET_PC, default 'h100, first fetch address after reset.
REQ-004 SHALL have parameter PC_STEP, default 2, address increment per instruction.
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port: mem_addr  output  ADDR_WIDTH  RAM address, equal to pc.
REQ-008 SHALL have port: mem_cs  output  1  RAM chip select.
REQ-009 SHALL have port: mem_oe  output  1  RAM output enable (read).
REQ-010 SHALL have port: mem_we  output  1  RAM write enable, constant 0.
REQ-011 SHALL have port: mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after the address cycle.
REQ-012 SHALL have port: ir_data  output  DATA_WIDTH  fetched instruction to decode/execute.
REQ-013 SHALL have port: ir_pc  output  ADDR_WIDTH  address ir_data was fetched from.
REQ-014 SHALL have port: ir_valid  output  1  ir_data/ir_pc valid.
REQ-015 SHALL have port: ir_ready  input  1  execute stage accepts instruction.
REQ-016 SHALL have port: redirect_valid  input  1  jump/skip taken; load new pc.
REQ-017 SHALL have port: redirect_pc  input  ADDR_WIDTH  jump target.
REQ-018 SHALL have port: halt  input  1  stop fetching (halt opcode decoded).
REQ-019 SHALL have port: halted  output  1  unit in HALT state.

Function
REQ-020 SHALL implement states ADDR, WAIT, HOLD, HALT.
REQ-021 ADDR: mem_cs=1, mem_oe=1, mem_addr=pc; next WAIT; if halt=1, no read issued (mem_cs=0), next HALT.
REQ-022 WAIT: capture mem_rdata into ir_data, pc into ir_pc; set ir_valid=1; pc <= pc+PC_STEP; next HOLD.
REQ-023 HOLD: ir_valid=1, ir_data/ir_pc stable; ir_ready=1 -> ir_valid=0 next cycle, next ADDR (HALT if halt=1 same cycle); ir_ready=0 -> stay.
REQ-024 Minimum throughput SHALL be one instruction per 3 cycles (ADDR, WAIT, HOLD with ir_ready=1).
REQ-025 mem_cs and mem_oe SHALL be 0 in WAIT, HOLD and HALT.
REQ-026 HALT: halted=1, ir_valid=0, mem_cs=0; exit only by redirect_valid or rst.
REQ-027 redirect_valid=1 in any state: pc <= redirect_pc, ir_valid <= 0, in-flight read discarded, halted <= 0, next ADDR.
REQ-028 Priority SHALL be rst > redirect_valid > halt > ir_ready handshake.
REQ-029 redirect_valid with ir_ready=1 in HOLD: instruction counts as accepted; redirect wins for next pc.
REQ-030 pc+PC_STEP SHALL truncate to ADDR_WIDTH (wrap to 0 past max address).
REQ-031 ir_data SHALL NOT change while ir_valid=1 and ir_ready=0.

Reset
REQ-032 rst=1 at a clock edge: pc=RESET_PC, state=ADDR, ir_valid=0, ir_data=0, ir_pc=0, halted=0.
REQ-033 During reset cycles mem_cs=0, mem_oe=0, mem_we=0; first read issued the cycle after rst deasserts.
REQ-034 rst mid-fetch SHALL discard the pending read with no ir_valid pulse.

Configuration
REQ-035 Macro FETCH_STALL_CNT_EN defined: SHALL add output stall_cnt (16 bits), incremented each cycle in HOLD with ir_ready=0, saturating at 'hFFFF, cleared by rst.
REQ-036 Macro FETCH_STALL_CNT_EN undefined: stall_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 Reset, RAM[100]='h1000011E, ir_ready=1 -> mem_addr='h100 cycle 1, ir_valid=1 cycle 3 with ir_data='h1000011E, ir_pc='h100.
REQ-038 Straight-line, ir_ready=1 -> ir_pc sequence 'h100,'h102,'h104 at 3-cycle spacing.
REQ-039 ir_ready=0 for 5 cycles in HOLD -> ir_data stable, no new read, stall_cnt=5 (macro defined).
REQ-040 redirect_valid=1, redirect_pc='h11A during WAIT -> fetched word discarded, next mem_addr='h11A, next ir_pc='h11A.
REQ-041 halt=1 with handshake at ir_pc='h118 -> halted=1, mem_cs=0 indefinitely; redirect_pc='h100 -> resumes fetching 'h100.
REQ-042 pc=(2^ADDR_WIDTH)-2 fetched -> next mem_addr=0; rst asserted in WAIT -> no ir_valid, next mem_addr='h100.
